// File: rtl/fetch_unit.sv
// Sequential Y86-64 fetch stage: PC register, serial byte fetch over req/ack, field split.
// Optional: define FETCH_TIMEOUT_EN to abort a fetch with stat=ADR after TIMEOUT cycles without mem_ack.
module fetch_unit #(
  parameter int              PC_W     = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_in,
  input  logic            pc_load,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_ack,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      rA,
  output logic [3:0]      rB,
  output logic [63:0]     valC,
  output logic [PC_W-1:0] valP,
  output logic            fetch_done,
  output logic [2:0]      stat
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, HALT} state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  function automatic logic [3:0] instLength(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h7, 4'h8:             return 4'd9;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      default:                return 4'd1;
    endcase
  endfunction

  function automatic logic hasRegByte(input logic [3:0] ic);
    return (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
  endfunction

  // Byte index where the 8-byte constant starts; 0 means no constant.
  function automatic logic [3:0] constStart(input logic [3:0] ic);
    case (ic)
      4'h3, 4'h4, 4'h5: return 4'd2;
      4'h7, 4'h8:       return 4'd1;
      default:          return 4'd0;
    endcase
  endfunction

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [3:0]      idx;

  logic [3:0]      curIcode;
  logic [3:0]      curLen;
  logic            lastByte;
  logic            badOpcode;
  logic [PC_W:0]   nextAddr;
  logic [3:0]      cStart;
  logic [3:0]      cOff;
  logic [2:0]      cByte;
  logic            cSel;

  always_comb begin
    curIcode  = (idx == 4'd0) ? mem_rdata[7:4] : icode;
    curLen    = instLength(curIcode);
    lastByte  = ((idx + 4'd1) == curLen);
    badOpcode = (idx == 4'd0) && (mem_rdata[7:4] > 4'hB);
    nextAddr  = {1'b0, pc} + {{(PC_W-3){1'b0}}, idx} + {{PC_W{1'b0}}, 1'b1};
    cStart    = constStart(icode);
    cOff      = idx - cStart;
    cByte     = cOff[2:0];
    cSel      = (cStart != 4'd0) && (idx >= cStart);
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] waitCnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      idx        <= 4'd0;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      icode      <= 4'h0;
      ifun       <= 4'h0;
      rA         <= 4'hF;
      rB         <= 4'hF;
      valC       <= 64'd0;
      valP       <= '0;
      fetch_done <= 1'b0;
      stat       <= STAT_AOK;
`ifdef FETCH_TIMEOUT_EN
      waitCnt    <= '0;
`endif
    end else begin
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc       <= pc_in;
            idx      <= 4'd0;
            mem_addr <= pc_in;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end

        REQ: begin
          if (!mem_req) begin
            // First cycle after reset: idx is 0, so the address cannot overflow.
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ack) begin
`ifdef FETCH_TIMEOUT_EN
            waitCnt <= '0;
`endif
            idx <= idx + 4'd1;
            if (idx == 4'd0) begin
              icode <= mem_rdata[7:4];
              ifun  <= mem_rdata[3:0];
              rA    <= 4'hF;
              rB    <= 4'hF;
              valC  <= 64'd0;
              valP  <= pc + PC_W'(curLen);
            end else begin
              if (idx == 4'd1 && hasRegByte(icode)) begin
                rA <= mem_rdata[7:4];
                rB <= mem_rdata[3:0];
              end
              if (cSel)
                valC[{cByte, 3'b000} +: 8] <= mem_rdata;
            end

            if (badOpcode || lastByte || nextAddr[PC_W]) begin
              mem_req    <= 1'b0;
              fetch_done <= 1'b1;
              state      <= DONE;
              if (badOpcode)
                stat <= STAT_INS;
              else if (lastByte)
                stat <= (curIcode == 4'h0) ? STAT_HLT : STAT_AOK;
              else
                stat <= STAT_ADR;
            end else begin
              mem_addr <= nextAddr[PC_W-1:0];
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else begin
            if (int'(waitCnt) >= TIMEOUT - 1) begin
              waitCnt    <= '0;
              mem_req    <= 1'b0;
              fetch_done <= 1'b1;
              stat       <= STAT_ADR;
              state      <= DONE;
            end else begin
              waitCnt <= waitCnt + CNT_W'(1);
            end
          end
`endif
        end

        DONE: begin
          state <= (stat != STAT_AOK) ? HALT : IDLE;
        end

        HALT: begin
          state <= HALT;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
